fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
- Streams a configuration bitstream into the fpga_top configuration buses: brbselect, bsbselect, lbselect and the four IO select buses.
- Words arrive over a valid/ready interface and are written into per-region shadow registers.
- A commit command copies all shadows to the active outputs in one cycle, so the fabric never sees a half-written configuration.
- Sits between the host/test interface and fpga_top.

Parameters:
- wire_width, 7, tracks per channel
- lb_cfg_size, 18, config bits per logic block
- fpga_width, 5, tile columns
- fpga_height, 5, tile rows
- DW, 16, stream word width; fixed at 16 by the header format

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  DW  stream word (header, offset or payload)
- brbselect  out  H*W*wire_width*12  active block-routing config
- bsbselect  out  (H-1)*(W-1)*wire_width*wire_width*12  active switch-box config
- lbselect  out  W*H*lb_cfg_size  active logic-block config
- leftioselect, rightioselect, topioselect, bottomioselect  out  2*wire_width*H each  active IO config
- cfg_busy  out  1  state != HDR
- cfg_done  out  1  active config valid; set by commit, cleared by acceptance of next non-commit header
- cfg_err  out  1  sticky error; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - all shadow and active registers = 0, so every config output = 0
  - state=HDR; cfg_done=0, cfg_err=0, cfg_busy=0
  - s_ready=1 is permitted after rst_n deasserts
- Transfer occurs only on the rising edge with s_valid & s_ready. Words offered without ready are neither consumed nor lost.
- Header word layout: [15:13]=region, [12:0]=len (payload word count).
  - Region codes: 0 brb, 1 bsb, 2 lb, 3 left, 4 right, 5 top, 6 bottom, 7 commit.
- States:
  - HDR, s_ready=1:
    - region 7 -> COMMIT.
    - Otherwise latch region and len, clear cfg_done -> OFS.
  - OFS, s_ready=1:
    - Latch s_data as bit offset (ptr).
    - len==0 -> HDR; else -> DATA with remaining count = len.
  - DATA, s_ready=1: each accepted word writes shadow[region] bits ptr..ptr+15 = s_data[0..15], LSB first, replacing their old values.
    - ptr += 16, count -= 1.
    - count reaches 0 -> HDR.
  - COMMIT, s_ready=0, lasts 1 cycle: all seven active registers <= shadows; cfg_done=1 -> HDR.
- Shadow writes are visible on the outputs only after a commit. Outputs change only in the COMMIT cycle or at reset.
- Region sizes follow the output widths above; with default parameters:
  - brb 2100 bits, bsb 9408, lb 450, each IO region 70.
- Boundary rules:
  - Bits with index >= region size are dropped. Any dropped bit sets cfg_err; the in-range bits of that word are still written.
  - An offset >= region size is legal: all its data is dropped and cfg_err is set.
  - ptr is at least 15 bits wide and must not wrap inside a legal transfer.
  - A commit with no prior writes re-commits the current shadows; legal.
  - Back-to-back headers and commits need no idle cycles; throughput is 1 word/cycle except the commit cycle.
- Reset mid-transfer: all shadows, all active registers and the error flag are cleared, and state returns to HDR. No partial configuration survives.

Decomposition:
- Package fpga_cfg_pkg:
  - region code constants (REG_BRB..REG_COMMIT)
  - state enum {HDR, OFS, DATA, COMMIT}
  - header field positions
  - size functions for each region derived from the four shared parameters
- Sub-module cfg_region_shadow #(SIZE, DW):
  - ports: clk, rst_n, wr_en, wr_ptr, wr_data, commit, active out, overflow out
  - holds shadow and active registers, does the masked write at an offset, flags out-of-range bits
  - instantiated seven times; top level holds only the FSM, counters and output muxing

Test Plan:
- IO write then commit: stream 0x6001, 0x0000, 0x0001 -> leftioselect stays 0 until 0xE000 is sent; one cycle after the commit transfer leftioselect[0]=1, all other bits 0, cfg_done=1, cfg_err=0.
- BRB offset write: stream 0x0001, 0x0004, 0x0002, 0xE000 -> brbselect[5]=1, brbselect[4]=0, bits 6..19 are 0; other outputs unchanged.
- Overflow: stream 0x6001, 0x0040 (offset 64), 0xFFFF, 0xE000 -> leftioselect[69:64]=6'h3F, bits 0..63 unchanged, cfg_err=1 and held.
- Backpressure and stall: s_valid is held high across the commit -> s_ready=0 for exactly one cycle after the commit header, no word is lost. Dropping s_valid mid-DATA for 3 cycles gives an identical final config.
- Multi-word LB load: stream 0x4003, 0x0000, 0x1234, 0x5678, 0x9ABC, 0xE000 -> lbselect[47:0]=48'h9ABC_5678_1234.
- Reset mid-DATA: rst_n=0 after the 2nd of 3 payload words -> all outputs 0, cfg_busy=0, cfg_done=0. A subsequent full IO sequence works normally.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared constants, header layout, FSM states and region-size helpers for the configuration loader.
package fpga_cfg_pkg;

  // Stream word and header field geometry
  localparam int unsigned HDR_W          = 16;
  localparam int unsigned REGION_W       = 3;
  localparam int unsigned LEN_W          = 13;
  localparam int unsigned HDR_REGION_MSB = 15;
  localparam int unsigned HDR_REGION_LSB = 13;
  localparam int unsigned HDR_LEN_MSB    = 12;
  localparam int unsigned HDR_LEN_LSB    = 0;

  // Bit pointer wide enough that offset 0xFFFF plus a maximum-length payload never wraps
  localparam int unsigned PTR_W = 18;

  localparam int unsigned NUM_REGIONS = 7;

  // Region codes carried in the header
  localparam logic [REGION_W-1:0] REG_BRB    = 3'd0;
  localparam logic [REGION_W-1:0] REG_BSB    = 3'd1;
  localparam logic [REGION_W-1:0] REG_LB     = 3'd2;
  localparam logic [REGION_W-1:0] REG_LEFT   = 3'd3;
  localparam logic [REGION_W-1:0] REG_RIGHT  = 3'd4;
  localparam logic [REGION_W-1:0] REG_TOP    = 3'd5;
  localparam logic [REGION_W-1:0] REG_BOTTOM = 3'd6;
  localparam logic [REGION_W-1:0] REG_COMMIT = 3'd7;

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    OFS    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [REGION_W-1:0] region;
    logic [LEN_W-1:0]    len;
  } hdr_t;

  // Block-routing config bits: 12 selects per track per tile
  function automatic int unsigned brb_size(input int unsigned ww, input int unsigned w,
                                           input int unsigned h);
    return h * w * ww * 12;
  endfunction

  // Switch-box config bits: interior tiles only
  function automatic int unsigned bsb_size(input int unsigned ww, input int unsigned w,
                                           input int unsigned h);
    return (h - 1) * (w - 1) * ww * ww * 12;
  endfunction

  // Logic-block config bits
  function automatic int unsigned lb_size(input int unsigned lbs, input int unsigned w,
                                          input int unsigned h);
    return w * h * lbs;
  endfunction

  // One IO edge: two selects per track per row
  function automatic int unsigned io_size(input int unsigned ww, input int unsigned h);
    return 2 * ww * h;
  endfunction

endpackage

// File: rtl/cfg_region_shadow.sv
// One configuration region: shadow register written 16 bits at a time, copied to active on commit.
module cfg_region_shadow
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned SIZE = 70,
  parameter int unsigned DW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             commit_i,
  output logic [SIZE-1:0]  active_o,
  output logic             overflow_o
);

  localparam int unsigned END_W = PTR_W + 1;

  logic [SIZE-1:0] shadow_q;
  logic [SIZE-1:0] shadow_d;
  logic [SIZE-1:0] active_q;
  logic [SIZE-1:0] mask;
  logic [SIZE-1:0] data_sh;
  logic            drops;
  logic            overflow_q;

  // Masked write: shifting past SIZE discards out-of-range bits, so an offset beyond the region writes nothing
  always_comb begin
    mask     = SIZE'({DW{1'b1}}) << wr_ptr_i;
    data_sh  = SIZE'(wr_data_i) << wr_ptr_i;
    drops    = (END_W'(wr_ptr_i) + END_W'(DW)) > END_W'(SIZE);
    shadow_d = shadow_q;
    if (wr_en_i) begin
      shadow_d = (shadow_q & ~mask) | (data_sh & mask);
    end
  end

  // Shadow, active copy and one-cycle overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      overflow_q <= wr_en_i && drops;
      if (commit_i) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active_o   = active_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Stream-to-config loader: parses header/offset/payload words into region shadows and commits them atomically.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned wire_width  = 7,
  parameter int unsigned lb_cfg_size = 18,
  parameter int unsigned fpga_width  = 5,
  parameter int unsigned fpga_height = 5,
  parameter int unsigned DW          = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    s_valid,
  output logic                                                    s_ready,
  input  logic [DW-1:0]                                           s_data,
  output logic [brb_size(wire_width, fpga_width, fpga_height)-1:0] brbselect,
  output logic [bsb_size(wire_width, fpga_width, fpga_height)-1:0] bsbselect,
  output logic [lb_size(lb_cfg_size, fpga_width, fpga_height)-1:0] lbselect,
  output logic [io_size(wire_width, fpga_height)-1:0]              leftioselect,
  output logic [io_size(wire_width, fpga_height)-1:0]              rightioselect,
  output logic [io_size(wire_width, fpga_height)-1:0]              topioselect,
  output logic [io_size(wire_width, fpga_height)-1:0]              bottomioselect,
  output logic                                                    cfg_busy,
  output logic                                                    cfg_done,
  output logic                                                    cfg_err
);

  localparam int unsigned BRB_SIZE = brb_size(wire_width, fpga_width, fpga_height);
  localparam int unsigned BSB_SIZE = bsb_size(wire_width, fpga_width, fpga_height);
  localparam int unsigned LB_SIZE  = lb_size(lb_cfg_size, fpga_width, fpga_height);
  localparam int unsigned IO_SIZE  = io_size(wire_width, fpga_height);

  state_e                  state_q;
  state_e                  state_d;
  logic [REGION_W-1:0]     region_q;
  logic [LEN_W-1:0]        count_q;
  logic [PTR_W-1:0]        ptr_q;
  logic                    s_ready_q;
  logic                    cfg_busy_q;
  logic                    cfg_done_q;
  logic                    cfg_err_q;

  hdr_t                    hdr;
  logic                    fire;
  logic                    hdr_acc_c;
  logic                    ofs_acc_c;
  logic                    data_acc_c;
  logic                    commit_c;
  logic [NUM_REGIONS-1:0]  wr_en_c;
  logic [NUM_REGIONS-1:0]  ovf;

  assign hdr  = hdr_t'(s_data);
  assign fire = s_valid && s_ready_q;

  // State register plus the status flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      s_ready_q  <= 1'b1;
      cfg_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d != COMMIT);
      cfg_busy_q <= (state_d != HDR);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR: begin
        if (fire) begin
          state_d = (hdr.region == REG_COMMIT) ? COMMIT : OFS;
        end
      end
      OFS: begin
        if (fire) begin
          state_d = (count_q == '0) ? HDR : DATA;
        end
      end
      DATA: begin
        if (fire && (count_q == LEN_W'(1))) begin
          state_d = HDR;
        end
      end
      COMMIT: begin
        state_d = HDR;
      end
    endcase
  end

  // Per-state strobes for the datapath and the region write enables
  always_comb begin
    hdr_acc_c  = 1'b0;
    ofs_acc_c  = 1'b0;
    data_acc_c = 1'b0;
    commit_c   = 1'b0;
    wr_en_c    = '0;
    unique case (state_q)
      HDR: begin
        hdr_acc_c = fire && (hdr.region != REG_COMMIT);
      end
      OFS: begin
        ofs_acc_c = fire;
      end
      DATA: begin
        data_acc_c = fire;
        wr_en_c    = NUM_REGIONS'(fire) << region_q;
      end
      COMMIT: begin
        commit_c = 1'b1;
      end
    endcase
  end

  // Header latch, bit pointer, remaining count and done/error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q   <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (hdr_acc_c) begin
        region_q   <= hdr.region;
        count_q    <= hdr.len;
        cfg_done_q <= 1'b0;
      end
      if (ofs_acc_c) begin
        ptr_q <= PTR_W'(s_data);
      end
      if (data_acc_c) begin
        ptr_q   <= ptr_q + PTR_W'(DW);
        count_q <= count_q - LEN_W'(1);
      end
      if (commit_c) begin
        cfg_done_q <= 1'b1;
      end
      if (|ovf) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  cfg_region_shadow #(.SIZE(BRB_SIZE), .DW(DW)) u_brb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_BRB]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (brbselect),
    .overflow_o(ovf[REG_BRB])
  );

  cfg_region_shadow #(.SIZE(BSB_SIZE), .DW(DW)) u_bsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_BSB]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (bsbselect),
    .overflow_o(ovf[REG_BSB])
  );

  cfg_region_shadow #(.SIZE(LB_SIZE), .DW(DW)) u_lb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_LB]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (lbselect),
    .overflow_o(ovf[REG_LB])
  );

  cfg_region_shadow #(.SIZE(IO_SIZE), .DW(DW)) u_left (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_LEFT]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (leftioselect),
    .overflow_o(ovf[REG_LEFT])
  );

  cfg_region_shadow #(.SIZE(IO_SIZE), .DW(DW)) u_right (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_RIGHT]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (rightioselect),
    .overflow_o(ovf[REG_RIGHT])
  );

  cfg_region_shadow #(.SIZE(IO_SIZE), .DW(DW)) u_top (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_TOP]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (topioselect),
    .overflow_o(ovf[REG_TOP])
  );

  cfg_region_shadow #(.SIZE(IO_SIZE), .DW(DW)) u_bottom (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c[REG_BOTTOM]),
    .wr_ptr_i  (ptr_q),
    .wr_data_i (s_data),
    .commit_i  (commit_c),
    .active_o  (bottomioselect),
    .overflow_o(ovf[REG_BOTTOM])
  );

  assign s_ready  = s_ready_q;
  assign cfg_busy = cfg_busy_q;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed and randomized bench for fpga_cfg_loader against a bit-level model of the region shadows.
module tb_fpga_cfg_loader;

  localparam int WW    = 7;
  localparam int LBS   = 18;
  localparam int FW    = 5;
  localparam int FH    = 5;
  localparam int BRB_N = FH * FW * WW * 12;
  localparam int BSB_N = (FH - 1) * (FW - 1) * WW * WW * 12;
  localparam int LB_N  = FW * FH * LBS;
  localparam int IO_N  = 2 * WW * FH;
  localparam int MAXN  = BSB_N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [15:0]       s_data;
  logic [BRB_N-1:0]  brbselect;
  logic [BSB_N-1:0]  bsbselect;
  logic [LB_N-1:0]   lbselect;
  logic [IO_N-1:0]   leftioselect;
  logic [IO_N-1:0]   rightioselect;
  logic [IO_N-1:0]   topioselect;
  logic [IO_N-1:0]   bottomioselect;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;

  fpga_cfg_loader #(
    .wire_width (WW),
    .lb_cfg_size(LBS),
    .fpga_width (FW),
    .fpga_height(FH),
    .DW         (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .brbselect     (brbselect),
    .bsbselect     (bsbselect),
    .lbselect      (lbselect),
    .leftioselect  (leftioselect),
    .rightioselect (rightioselect),
    .topioselect   (topioselect),
    .bottomioselect(bottomioselect),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: per-region shadow/active bit vectors and flags
  logic [MAXN-1:0] m_sh  [7];
  logic [MAXN-1:0] m_act [7];
  int              rsize [7];
  logic            m_done;
  logic            m_err;
  int              checks;
  int              failures;
  int              last_wait;
  int              hdr_wait;
  logic [15:0]     pay [$];

  task automatic chk_vec(input string tag, input logic [MAXN-1:0] obs, input logic [MAXN-1:0] exp);
    int fd;
    int ws;
    checks++;
    assert (obs === exp) else begin
      failures++;
      fd = 0;
      for (int i = MAXN - 1; i >= 0; i--) if (obs[i] !== exp[i]) fd = i;
      ws = (fd > MAXN - 64) ? MAXN - 64 : fd;
      $error("FAIL %s first_diff_bit=%0d window_lsb=%0d observed=%h expected=%h",
             tag, fd, ws, obs[ws +: 64], exp[ws +: 64]);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_active(input string tag);
    chk_vec({tag, "_brb"},    MAXN'(brbselect),      m_act[0]);
    chk_vec({tag, "_bsb"},    MAXN'(bsbselect),      m_act[1]);
    chk_vec({tag, "_lb"},     MAXN'(lbselect),       m_act[2]);
    chk_vec({tag, "_left"},   MAXN'(leftioselect),   m_act[3]);
    chk_vec({tag, "_right"},  MAXN'(rightioselect),  m_act[4]);
    chk_vec({tag, "_top"},    MAXN'(topioselect),    m_act[5]);
    chk_vec({tag, "_bottom"}, MAXN'(bottomioselect), m_act[6]);
  endtask

  task automatic check_all(input string tag);
    check_active(tag);
    chk_bit({tag, "_done"}, cfg_done, m_done);
    chk_bit({tag, "_err"},  cfg_err,  m_err);
    chk_bit({tag, "_busy"}, cfg_busy, 1'b0);
  endtask

  // Offer one word (after an optional idle gap) and return once it has been taken
  task automatic send_word(input logic [15:0] w, input int stall);
    int t;
    if (stall > 0) begin
      s_valid = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (s_ready !== 1'b1 && t < 16) begin
      @(posedge clk);
      #1;
      t++;
    end
    last_wait = t;
    if (s_ready !== 1'b1) chk_bit("ready_timeout", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic model_write(input int r, input int p, input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      if (p + k < rsize[r]) m_sh[r][p + k] = w[k];
      else m_err = 1'b1;
    end
  endtask

  // Header + offset + the words in pay[] to region r
  task automatic write_region(input int r, input int off, input bit stall_mid);
    logic [15:0] hw;
    hw = {3'(r), 13'(pay.size())};
    send_word(hw, 0);
    hdr_wait = last_wait;
    m_done = 1'b0;
    chk_bit("hdr_clears_done", cfg_done, m_done);
    chk_bit("busy_after_hdr", cfg_busy, 1'b1);
    send_word(16'(off), 0);
    for (int i = 0; i < pay.size(); i++) begin
      send_word(pay[i], (stall_mid && i == pay.size() / 2) ? 3 : 0);
      model_write(r, off + 16 * i, pay[i]);
    end
  endtask

  task automatic do_commit(input bit settle);
    send_word(16'hE000, 0);
    chk_bit("commit_ready_low", s_ready, 1'b0);
    chk_bit("commit_busy", cfg_busy, 1'b1);
    for (int i = 0; i < 7; i++) m_act[i] = m_sh[i];
    m_done = 1'b1;
    if (settle) begin
      @(posedge clk);
      #1;
      check_all("commit");
      chk_bit("ready_back", s_ready, 1'b1);
    end
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("ready_after_reset", s_ready, 1'b1);
    check_all("after_reset");
  endtask

  initial begin
    int r;
    int off;
    int len;
    int sel;
    checks   = 0;
    failures = 0;
    s_valid  = 1'b0;
    s_data   = '0;
    rst_n    = 1'b0;
    rsize    = '{BRB_N, BSB_N, LB_N, IO_N, IO_N, IO_N, IO_N};

    apply_reset();

    // Left IO: single bit 0, invisible until commit
    pay = '{16'h0001};
    write_region(3, 0, 1'b0);
    check_active("t1_pre");
    do_commit(1'b1);
    chk_vec("t1_left", MAXN'(leftioselect), MAXN'(70'h1));
    chk_bit("t1_done", cfg_done, 1'b1);
    chk_bit("t1_err", cfg_err, 1'b0);

    // BRB at bit offset 4
    pay = '{16'h0002};
    write_region(0, 4, 1'b0);
    check_active("t2_pre");
    do_commit(1'b1);
    chk_vec("t2_brb", MAXN'(brbselect), MAXN'(2100'h20));

    // Multi-word LB load
    pay = '{16'h1234, 16'h5678, 16'h9ABC};
    write_region(2, 0, 1'b0);
    check_active("t5_pre");
    do_commit(1'b1);
    chk_vec("t5_lb", MAXN'(lbselect), MAXN'(450'h9ABC56781234));

    // Same LB data reloaded with a valid gap mid-payload
    pay = '{16'h0000, 16'h0000, 16'h0000};
    write_region(2, 0, 1'b0);
    pay = '{16'h1234, 16'h5678, 16'h9ABC};
    write_region(2, 0, 1'b1);
    do_commit(1'b1);
    chk_vec("stall_lb", MAXN'(lbselect), MAXN'(450'h9ABC56781234));

    // Overflow straddling the end of the left IO region
    pay = '{16'hFFFF};
    write_region(3, 64, 1'b0);
    do_commit(1'b1);
    chk_vec("ovf_left", MAXN'(leftioselect), MAXN'(70'h3F0000000000000001));
    chk_bit("ovf_err", cfg_err, 1'b1);

    // Commit with nothing written; error stays sticky
    do_commit(1'b1);
    chk_bit("ovf_err_held", cfg_err, 1'b1);

    // Offset wholly beyond region
    pay = '{16'hFFFF};
    write_region(5, 70, 1'b0);
    do_commit(1'b1);

    // Valid held across commit: next header waits exactly one cycle
    pay = '{16'hA5A5};
    write_region(4, 0, 1'b0);
    do_commit(1'b0);
    pay = '{16'h5A5A, 16'h00FF};
    write_region(6, 3, 1'b0);
    chk_int("bp_wait", hdr_wait, 1);
    do_commit(1'b1);

    // Reset after 2 of 3 payload words
    send_word({3'd2, 13'd3}, 0);
    send_word(16'h0000, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    apply_reset();

    // Normal IO sequence after reset
    pay = '{16'h0001};
    write_region(3, 0, 1'b0);
    do_commit(1'b1);
    chk_vec("post_rst_left", MAXN'(leftioselect), MAXN'(70'h1));

    // Randomized region writes with occasional commits
    for (int it = 0; it < 60; it++) begin
      r   = $urandom_range(0, 6);
      sel = $urandom_range(0, 9);
      if (sel == 0)      off = rsize[r] + $urandom_range(0, 40);
      else if (sel == 1) off = rsize[r] - $urandom_range(1, 15);
      else               off = $urandom_range(0, rsize[r] - 1);
      len = $urandom_range(0, 5);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(16'($urandom));
      write_region(r, off, ($urandom_range(0, 3) == 0));
      check_active("rnd_pre");
      if ($urandom_range(0, 2) == 0) do_commit(1'b1);
    end
    do_commit(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
